// File: rtl/split_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : split_mem_pkg
//  Description : Shared types and constants for the split-transaction target
//                memory: FSM state encoding and the latency counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package split_mem_pkg;

    // Width of the read-latency counter; READ_LATENCY must fit in it.
    localparam int c_LAT_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WDATA = 3'd1,
        WACK  = 3'd2,
        SPLIT = 3'd3,
        WAIT  = 3'd4,
        REQ   = 3'd5,
        SEND  = 3'd6,
        RACK  = 3'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/split_mem_ram.sv
`default_nettype none
// ============================================================================
//  Module      : split_mem_ram
//  Description : Single-port byte RAM, 2**ADDR_W entries, synchronous write,
//                registered read. Contents are not reset.
//  Ports       : clk   - clock
//                we    - write enable
//                addr  - read/write address
//                wdata - write data
//                rdata - registered read data (mem[addr] of previous cycle)
//  Revision    : 1.0 - initial release
// ============================================================================
module split_mem_ram #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);

    logic [7:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        rdata <= r_mem[addr];
    end

endmodule
`default_nettype wire

// File: rtl/split_target_mem.sv
`default_nettype none
// ============================================================================
//  Module      : split_target_mem
//  Description : Bus target with local byte memory. Writes complete in place;
//                reads are split: accepted with target_split_ack, then the
//                data is returned READ_LATENCY cycles later once the bus is
//                re-granted via split_req/split_grant.
//  Ports       : clk, rst (sync, active-high)
//                addr_in/addr_in_valid/rw   - transaction request
//                data_in/data_in_valid      - write data
//                split_grant                - bus grant for the response phase
//                target_ready               - idle, can accept a request
//                target_ack                 - completion pulse
//                target_split_ack           - read accepted, response deferred
//                split_req                  - requesting bus for read response
//                data_out/data_out_valid    - read data
//  Revision    : 1.0 - initial release
// ============================================================================
module split_target_mem
    import split_mem_pkg::*;
#(
    parameter int ADDR_W       = 12,
    parameter int READ_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr_in,
    input  logic        addr_in_valid,
    input  logic [7:0]  data_in,
    input  logic        data_in_valid,
    input  logic        rw,
    input  logic        split_grant,
    output logic        target_ready,
    output logic        target_ack,
    output logic        target_split_ack,
    output logic        split_req,
    output logic [7:0]  data_out,
    output logic        data_out_valid
);

    localparam logic [c_LAT_W-1:0] c_LAT_LOAD = c_LAT_W'(READ_LATENCY - 1);

    state_t             r_state;
    state_t             w_next;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_rw;
    logic [c_LAT_W-1:0] r_cnt;
    logic [7:0]         r_rdata;
    logic [ADDR_W-1:0]  w_ram_addr;
    logic [7:0]         w_ram_q;
    logic               w_we;

    generate
        if (ADDR_W < 16) begin : g_unused_addr
            logic w_unused_addr;
            assign w_unused_addr = ^addr_in[15:ADDR_W];
        end
    endgenerate

    // In IDLE the RAM is addressed straight from the bus so the registered
    // read output already holds mem[addr] during the SPLIT cycle.
    assign w_ram_addr = (r_state == IDLE) ? addr_in[ADDR_W-1:0] : r_addr;

    // A write is suppressed while rst is high so an abandoned transaction
    // cannot modify memory.
    assign w_we = !rst &&
                  (((r_state == IDLE) && addr_in_valid && rw && data_in_valid) ||
                   ((r_state == WDATA) && data_in_valid && r_rw));

    split_mem_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (w_we),
        .addr  (w_ram_addr),
        .wdata (data_in),
        .rdata (w_ram_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_rw    <= 1'b0;
            r_cnt   <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == IDLE) && addr_in_valid) begin
                r_addr <= addr_in[ADDR_W-1:0];
                r_rw   <= rw;
            end
            if (r_state == SPLIT) begin
                r_rdata <= w_ram_q;
                r_cnt   <= c_LAT_LOAD;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - 8'd1;
            end
        end
    end

    always_comb begin
        w_next           = r_state;
        target_ready     = 1'b0;
        target_ack       = 1'b0;
        target_split_ack = 1'b0;
        split_req        = 1'b0;
        data_out         = 8'h00;
        data_out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                target_ready = 1'b1;
                if (addr_in_valid) begin
                    if (!rw)               w_next = SPLIT;
                    else if (data_in_valid) w_next = WACK;
                    else                   w_next = WDATA;
                end
            end
            WDATA: begin
                if (data_in_valid) w_next = WACK;
            end
            WACK: begin
                target_ack = 1'b1;
                w_next     = IDLE;
            end
            SPLIT: begin
                target_split_ack = 1'b1;
                // With a latency of one there are no idle cycles to count.
                w_next = (READ_LATENCY == 1) ? REQ : WAIT;
            end
            WAIT: begin
                // Counter reaches zero on this edge: REQ starts exactly
                // READ_LATENCY cycles after SPLIT.
                if (r_cnt <= 8'd1) w_next = REQ;
            end
            REQ: begin
                split_req = 1'b1;
                if (split_grant) w_next = SEND;
            end
            SEND: begin
                split_req      = 1'b1;
                data_out       = r_rdata;
                data_out_valid = 1'b1;
                w_next         = RACK;
            end
            RACK: begin
                split_req  = 1'b1;
                target_ack = 1'b1;
                w_next     = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_split_target_mem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_split_target_mem
//  Description : Self-checking bench for split_target_mem: directed scenarios
//                followed by random writes/reads against a byte-array model
//                with cycle timing derived from READ_LATENCY.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_split_target_mem;

    localparam int c_ADDR_W   = 12;
    localparam int c_READ_LAT = 4;

    logic        clk;
    logic        rst;
    logic [15:0] addr_in;
    logic        addr_in_valid;
    logic [7:0]  data_in;
    logic        data_in_valid;
    logic        rw;
    logic        split_grant;
    logic        target_ready;
    logic        target_ack;
    logic        target_split_ack;
    logic        split_req;
    logic [7:0]  data_out;
    logic        data_out_valid;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mdl_mem [2**c_ADDR_W];
    bit         mdl_vld [2**c_ADDR_W];

    split_target_mem #(
        .ADDR_W       (c_ADDR_W),
        .READ_LATENCY (c_READ_LAT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .addr_in          (addr_in),
        .addr_in_valid    (addr_in_valid),
        .data_in          (data_in),
        .data_in_valid    (data_in_valid),
        .rw               (rw),
        .split_grant      (split_grant),
        .target_ready     (target_ready),
        .target_ack       (target_ack),
        .target_split_ack (target_split_ack),
        .split_req        (split_req),
        .data_out         (data_out),
        .data_out_valid   (data_out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // {ready, ack, split_ack, split_req, data_out_valid, data_out}
    function automatic logic [15:0] outs();
        return {3'b000, target_ready, target_ack, target_split_ack, split_req,
                data_out_valid, data_out};
    endfunction

    function automatic logic [15:0] idle_outs();
        return 16'h1000;
    endfunction

    task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int dly);
        chk("wr_ready", outs(), idle_outs());
        addr_in = a; addr_in_valid = 1'b1; rw = 1'b1;
        data_in = d; data_in_valid = (dly == 0);
        step();
        addr_in_valid = 1'b0; data_in_valid = 1'b0;
        for (int i = 1; i < dly; i++) begin
            chk("wr_wdata_hold", outs(), 16'h0000);
            data_in = 8'($urandom);
            // a stray request while waiting for data must be ignored
            addr_in_valid = (i == 1); addr_in = 16'($urandom); rw = 1'b0;
            step();
        end
        if (dly > 0) begin
            chk("wr_wdata_last", outs(), 16'h0000);
            addr_in_valid = 1'b0; data_in = d; data_in_valid = 1'b1;
            step();
            data_in_valid = 1'b0;
        end
        chk("wr_ack", outs(), 16'h0800);
        step();
        chk("wr_back_idle", outs(), idle_outs());
        mdl_mem[a[c_ADDR_W-1:0]] = d;
        mdl_vld[a[c_ADDR_W-1:0]] = 1'b1;
    endtask

    task automatic do_read(input logic [15:0] a, input int g, input bit inject);
        logic [7:0] exp;
        exp = mdl_mem[a[c_ADDR_W-1:0]];
        chk("rd_ready", outs(), idle_outs());
        addr_in = a; addr_in_valid = 1'b1; rw = 1'b0; split_grant = (g == 0);
        step();
        addr_in_valid = 1'b0;
        chk("rd_split_ack", outs(), 16'h0400);
        for (int i = 2; i <= c_READ_LAT; i++) begin
            step();
            chk("rd_wait_quiet", outs(), 16'h0000);
            addr_in_valid = inject && (i == 3);
            addr_in = 16'($urandom); rw = 1'($urandom);
            if (g > 0) split_grant = 1'($urandom);
        end
        step();
        addr_in_valid = 1'b0;
        split_grant   = (g == 0);
        for (int k = 0; k <= g; k++) begin
            chk("rd_req_hold", outs(), 16'h0200);
            split_grant = (k == g);
            step();
        end
        chk("rd_send", outs(), {8'h03, exp});
        split_grant = 1'($urandom);
        step();
        chk("rd_rack", outs(), 16'h0A00);
        split_grant = 1'($urandom);
        step();
        split_grant = 1'b0;
        chk("rd_back_idle", outs(), idle_outs());
    endtask

    task automatic do_reset();
        rst = 1'b1;
        addr_in_valid = 1'b0; data_in_valid = 1'b0; split_grant = 1'b0;
        step();
        rst = 1'b0;
    endtask

    logic [15:0] pool [16];
    logic [15:0] a;
    int          idx;

    initial begin
        rst = 1'b1; addr_in = '0; addr_in_valid = 1'b0; data_in = '0;
        data_in_valid = 1'b0; rw = 1'b0; split_grant = 1'b0;
        step();
        step();
        chk("reset_outs", outs(), idle_outs());
        rst = 1'b0;
        step();
        chk("post_reset_idle", outs(), idle_outs());

        // address and data in the same cycle
        do_write(16'h0123, 8'h5A, 0);
        // data three cycles after address
        do_write(16'h0040, 8'hC3, 3);
        // read with grant tied high
        do_read(16'h0123, 0, 1'b0);
        // upper address bits ignored, grant delayed 10 cycles
        do_read(16'hF040, 10, 1'b0);
        // stray request during WAIT
        do_read(16'h0123, 2, 1'b1);

        // reset while requesting the bus
        addr_in = 16'h0040; addr_in_valid = 1'b1; rw = 1'b0; split_grant = 1'b0;
        step();
        addr_in_valid = 1'b0;
        for (int i = 0; i < c_READ_LAT + 2; i++) step();
        chk("rst_pre_req", outs(), 16'h0200);
        do_reset();
        chk("rst_in_req", outs(), idle_outs());
        step();
        chk("rst_in_req_idle", outs(), idle_outs());
        do_read(16'h0123, 0, 1'b0);

        // reset while waiting for write data, with data presented alongside
        addr_in = 16'h0123; addr_in_valid = 1'b1; rw = 1'b1; data_in_valid = 1'b0;
        step();
        addr_in_valid = 1'b0;
        step();
        data_in = 8'hFF;
        rst = 1'b1; data_in_valid = 1'b1;
        step();
        rst = 1'b0; data_in_valid = 1'b0;
        chk("rst_in_wdata", outs(), idle_outs());
        step();
        do_read(16'h0123, 1, 1'b0);

        // random traffic over a small address pool so reads hit written data
        for (int i = 0; i < 16; i++) pool[i] = 16'(16'h0200 + i * 37);
        for (int n = 0; n < 40; n++) begin
            idx = int'($urandom_range(0, 15));
            a   = {4'($urandom), pool[idx][11:0]};
            if (!mdl_vld[a[c_ADDR_W-1:0]] || ($urandom_range(0, 1) == 1))
                do_write(a, 8'($urandom), int'($urandom_range(0, 3)));
            else
                do_read(a, int'($urandom_range(0, 4)), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/split_target_mem.md
SPLIT_TARGET_MEM -- requirements
Module: split_target_mem

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, local memory address bits (depth 2**ADDR_W bytes).
REQ-002 SHALL have parameter READ_LATENCY, default 4, idle cycles between split and re-request, legal range 1..255.
REQ-003 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port addr_in  in  16  transaction address; low ADDR_W bits used, upper bits ignored.
REQ-006 SHALL have port addr_in_valid  in  1  addr_in qualifier, one-cycle pulse.
REQ-007 SHALL have port data_in  in  8  write data.
REQ-008 SHALL have port data_in_valid  in  1  data_in qualifier.
REQ-009 SHALL have port rw  in  1  direction; 1 = write, 0 = read; sampled with addr_in_valid.
REQ-010 SHALL have port split_grant  in  1  bus grant for split response phase.
REQ-011 SHALL have port target_ready  out  1  high only in IDLE.
REQ-012 SHALL have port target_ack  out  1  one-cycle completion pulse.
REQ-013 SHALL have port target_split_ack  out  1  one-cycle pulse: read accepted, response deferred.
REQ-014 SHALL have port split_req  out  1  request bus to return read data.
REQ-015 SHALL have port data_out  out  8  read data, 0 when data_out_valid low.
REQ-016 SHALL have port data_out_valid  out  1  data_out qualifier, one-cycle pulse.

Function
REQ-017 SHALL implement FSM states IDLE, WDATA, WACK, SPLIT, WAIT, REQ, SEND, RACK.
REQ-018 IDLE: on addr_in_valid, SHALL latch addr_in[ADDR_W-1:0] and rw; rw=1 -> WDATA, rw=0 -> SPLIT.
REQ-019 IDLE with addr_in_valid, rw=1 and data_in_valid same cycle: SHALL write mem immediately and go to WACK (skip WDATA).
REQ-020 WDATA: on data_in_valid SHALL write data_in to mem[latched addr], -> WACK; waits indefinitely otherwise.
REQ-021 WACK: target_ack=1 for exactly one cycle, -> IDLE.
REQ-022 SPLIT: target_split_ack=1 one cycle; read mem[latched addr] into rdata register; load counter with READ_LATENCY-1; -> WAIT.
REQ-023 WAIT: counter decrements each cycle; at counter==0 -> REQ (so split_req first rises READ_LATENCY cycles after the SPLIT cycle).
REQ-024 REQ: split_req=1 held until split_grant sampled high, then -> SEND; no timeout.
REQ-025 SEND: data_out=rdata, data_out_valid=1 one cycle, split_req=1, -> RACK.
REQ-026 RACK: target_ack=1 one cycle, split_req=1, -> IDLE; split_req low in IDLE.
REQ-027 split_grant withdrawn during SEND or RACK SHALL NOT alter sequence; block completes.
REQ-028 addr_in_valid/data_in_valid outside IDLE/WDATA respectively SHALL be ignored with no state change.
REQ-029 split_grant asserted outside REQ SHALL be ignored.
REQ-030 A write arriving while a read is deferred is impossible by construction (target_ready low from SPLIT through RACK); only one outstanding transaction.
REQ-031 Read-after-write to same address SHALL return the written byte.

Reset
REQ-032 rst high SHALL force IDLE, counter=0, rdata=0, all outputs 0 except target_ready=1 on the following cycle.
REQ-033 rst mid-transaction (any state) SHALL abandon it without issuing ack, split_ack or split_req; memory contents SHALL NOT be cleared.

Structure
REQ-034 State enum and READ_LATENCY width constant (8 bits) SHALL reside in shared package split_mem_pkg.
REQ-035 Storage SHALL be sub-module split_mem_ram: single-port, synchronous write, registered read, ADDR_W x 8, no reset.

Verification
REQ-036 Write 0x5A to 0x0123 (addr and data same cycle) -> target_ack one cycle later, target_ready back next cycle.
REQ-037 Write addr 0x0040 then data 0xC3 three cycles later -> state WDATA holds, target_ack cycle after data_in_valid.
REQ-038 Read 0x0123 after REQ-036, READ_LATENCY=4, split_grant tied high -> split_ack at T+1, split_req at T+5, data_out=0x5A valid T+6, target_ack T+7.
REQ-039 Read with split_grant delayed 10 cycles -> split_req held steady 10 cycles, then SEND/RACK exactly once.
REQ-040 addr_in_valid pulse during WAIT -> ignored; no second split_ack; original read completes correctly.
REQ-041 rst asserted in REQ state -> split_req low next cycle, target_ready=1, subsequent read of 0x0123 still returns 0x5A.
